// File: rtl/modulo_controle_ataque_pkg.sv
// Shared definitions for the naval-battle attack controller: board geometry,
// result codes, FSM states and the row/column to bit-index mapping.
package modulo_controle_ataque_pkg;

   localparam int CELLS  = 35;
   localparam int ROWS   = 7;
   localparam int COLS   = 5;
   localparam int ROW_W  = 3;
   localparam int COL_W  = 3;
   localparam int IDX_W  = 6;
   localparam int HIT_W  = 4;
   localparam int SHOT_W = 5;

   localparam logic [1:0] MODE_ATTACK = 2'b10;

   typedef enum logic [1:0] {
      RES_NONE   = 2'd0,
      RES_MISS   = 2'd1,
      RES_HIT    = 2'd2,
      RES_REJECT = 2'd3
   } result_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS,
      ST_EVAL,
      ST_RELEASE,
      ST_OVER
   } state_e;

   // Cell (r,c) lives at bit 34-(5r+c): row 0, column 0 is the MSB.
   function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
      return IDX_W'(CELLS - 1) - (IDX_W'(r) * IDX_W'(COLS) + IDX_W'(c));
   endfunction

endpackage

// File: rtl/modulo_controle_ataque_debounce.sv
// Fire-button conditioner: 2-flop synchronizer plus a stable-sample counter
// that the controller FSM clears and advances; flags press/release stability.
module modulo_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic clr_n,
   input  logic btn,
   input  logic cnt_clr,
   input  logic cnt_en,
   output logic sync,
   output logic press_det,
   output logic release_det
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          meta;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
         cnt  <= '0;
      end else begin
         meta <= btn;
         sync <= meta;
         if (cnt_clr)
            cnt <= '0;
         else if (cnt_en)
            cnt <= cnt + 1'b1;
      end
   end

   // The IDLE cycle that spots the rising sync is the first high sample, so
   // PRESS only needs DEBOUNCE_CYCLES-1 more; RELEASE counts all of its own.
   assign press_det   = sync && (cnt == CW'(DEBOUNCE_CYCLES - 2));
   assign release_det = !sync && (cnt == CW'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/modulo_controle_ataque.sv
// Attack controller: debounced fire button drives one registered shot update
// per press. Optional shot budget enabled by defining ATAQUE_SHOT_LIMIT_EN.
module modulo_controle_ataque
   import modulo_controle_ataque_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int HIT_TARGET      = 9,
   parameter int MAX_SHOTS       = 20
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              btn_fire,
   input  logic [1:0]        mode,
   input  logic [ROW_W-1:0]  row,
   input  logic [COL_W-1:0]  col,
   input  logic [CELLS-1:0]  ship_map,
   output logic [CELLS-1:0]  attack_map,
   output logic [CELLS-1:0]  hit_map,
   output logic [HIT_W-1:0]  hits,
   output logic [SHOT_W-1:0] shots,
   output logic [1:0]        result,
   output logic              shot_valid,
   output logic              game_over,
   output logic              busy
);

`ifdef ATAQUE_SHOT_LIMIT_EN
   localparam bit SHOT_LIMIT = 1'b1;
`else
   localparam bit SHOT_LIMIT = 1'b0;
`endif

   state_e state, state_n;

   logic sync, press_det, release_det;
   logic cnt_clr, cnt_en;

   modulo_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk         (clk),
      .clr_n       (clr_n),
      .btn         (btn_fire),
      .cnt_clr     (cnt_clr),
      .cnt_en      (cnt_en),
      .sync        (sync),
      .press_det   (press_det),
      .release_det (release_det)
   );

   logic              in_range, accept, is_ship, win, out_of_shots;
   logic [CELLS-1:0]  cell_mask;
   logic [HIT_W-1:0]  hits_inc;
   logic [SHOT_W-1:0] shots_inc;

   // Out-of-range coordinates yield an empty mask, so no bit is ever touched.
   always_comb begin
      in_range  = (row <= ROW_W'(ROWS - 1)) && (col <= COL_W'(COLS - 1));
      cell_mask = in_range ? (CELLS'(1) << cell_idx(row, col)) : '0;
      is_ship   = |(ship_map & cell_mask);
      accept    = (mode == MODE_ATTACK) && in_range && !(|(attack_map & cell_mask));
      hits_inc  = (hits == '1)  ? hits  : hits + 1'b1;
      shots_inc = (shots == '1) ? shots : shots + 1'b1;
      win       = accept && is_ship && (int'(hits_inc) >= HIT_TARGET);
      out_of_shots = SHOT_LIMIT && accept && (int'(shots_inc) >= MAX_SHOTS);
   end

   always_comb begin
      state_n = state;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (sync) state_n = ST_PRESS;
         end
         ST_PRESS: begin
            if (!sync)          state_n = ST_IDLE;
            else if (press_det) state_n = ST_EVAL;
            else                cnt_en  = 1'b1;
         end
         ST_EVAL: begin
            cnt_clr = 1'b1;
            state_n = (win || out_of_shots) ? ST_OVER : ST_RELEASE;
         end
         ST_RELEASE: begin
            if (sync)             cnt_clr = 1'b1;
            else if (release_det) state_n = ST_IDLE;
            else                  cnt_en  = 1'b1;
         end
         ST_OVER: state_n = ST_OVER;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state      <= ST_IDLE;
         attack_map <= '0;
         hit_map    <= '0;
         hits       <= '0;
         shots      <= '0;
         result     <= RES_NONE;
         shot_valid <= 1'b0;
         game_over  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         shot_valid <= (state == ST_EVAL);
         busy       <= (state_n != ST_IDLE);
         game_over  <= (state_n == ST_OVER);
         if (state == ST_EVAL) begin
            if (accept) begin
               attack_map <= attack_map | cell_mask;
               shots      <= shots_inc;
               if (is_ship) begin
                  hit_map <= hit_map | cell_mask;
                  hits    <= hits_inc;
                  result  <= RES_HIT;
               end else begin
                  result  <= RES_MISS;
               end
            end else begin
               result <= RES_REJECT;
            end
         end
      end
   end

endmodule

// File: tb/tb_modulo_controle_ataque.sv
// Directed bench for modulo_controle_ataque (DEBOUNCE_CYCLES=4, HIT_TARGET=2,
// MAX_SHOTS=3); shot-budget checks follow ATAQUE_SHOT_LIMIT_EN.
module tb_modulo_controle_ataque;

`ifdef ATAQUE_SHOT_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        clr_n;
   logic        btn_fire;
   logic [1:0]  mode;
   logic [2:0]  row, col;
   logic [34:0] ship_map, attack_map, hit_map;
   logic [3:0]  hits;
   logic [4:0]  shots;
   logic [1:0]  result;
   logic        shot_valid, game_over, busy;

   int tests = 0;
   int fails = 0;

   int   pulses, pcyc;
   logic go_at_pulse;

   modulo_controle_ataque #(
      .DEBOUNCE_CYCLES (4),
      .HIT_TARGET      (2),
      .MAX_SHOTS       (3)
   ) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .btn_fire   (btn_fire),
      .mode       (mode),
      .row        (row),
      .col        (col),
      .ship_map   (ship_map),
      .attack_map (attack_map),
      .hit_map    (hit_map),
      .hits       (hits),
      .shots      (shots),
      .result     (result),
      .shot_valid (shot_valid),
      .game_over  (game_over),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [34:0] bit_of(input int idx);
      logic [34:0] one;
      one = 35'd1;
      return one << idx;
   endfunction

   // Holds the button for 'hold' cycles, then watches 25 more cycles of release.
   task automatic fire(input logic [1:0] m, input logic [2:0] r, input logic [2:0] c,
                       input int hold);
      mode = m; row = r; col = c;
      pulses = 0; pcyc = -1; go_at_pulse = 1'b0;
      btn_fire = 1'b1;
      for (int i = 1; i <= hold + 25; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i == hold) btn_fire = 1'b0;
         if (shot_valid) begin
            pulses++;
            if (pcyc < 0) begin
               pcyc = i;
               go_at_pulse = game_over;
            end
         end
      end
   endtask

   task automatic do_reset();
      btn_fire = 1'b0;
      clr_n = 1'b0;
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      repeat (20) @(negedge clk);
      tests++;
      if ({attack_map, hit_map} !== 70'd0) begin
         fails++; $display("FAIL reset_maps: got %h %h want 0", attack_map, hit_map);
      end
      tests++;
      if ({hits, shots, result} !== 11'd0) begin
         fails++; $display("FAIL reset_counts: got hits=%0d shots=%0d result=%0d want 0", hits, shots, result);
      end
      tests++;
      if ({shot_valid, game_over, busy} !== 3'b000) begin
         fails++; $display("FAIL reset_flags: got %b want 000", {shot_valid, game_over, busy});
      end
   endtask

   task automatic test_first_hit();
      ship_map = bit_of(34) | bit_of(27);
      fire(2'b10, 3'd0, 3'd0, 30);
      tests++;
      if (pulses !== 1) begin
         fails++; $display("FAIL hit_pulses: got %0d want 1", pulses);
      end
      tests++;
      if (pcyc !== 7) begin
         fails++; $display("FAIL hit_latency: got %0d want 7", pcyc);
      end
      tests++;
      if (result !== 2'd2 || hits !== 4'd1 || shots !== 5'd1) begin
         fails++; $display("FAIL hit_state: got result=%0d hits=%0d shots=%0d want 2 1 1", result, hits, shots);
      end
      tests++;
      if (attack_map !== bit_of(34) || hit_map !== bit_of(34)) begin
         fails++; $display("FAIL hit_maps: got %h %h want %h", attack_map, hit_map, bit_of(34));
      end
   endtask

   task automatic test_glitch();
      fire(2'b10, 3'd4, 3'd4, 2);
      tests++;
      if (pulses !== 0 || busy !== 1'b0) begin
         fails++; $display("FAIL glitch: got pulses=%0d busy=%b want 0 0", pulses, busy);
      end
      tests++;
      if (shots !== 5'd1 || attack_map !== bit_of(34)) begin
         fail_count_msg("glitch_state");
      end
   endtask

   task automatic fail_count_msg(input string name);
      fails++;
      $display("FAIL %s: got shots=%0d attack=%h", name, shots, attack_map);
   endtask

   task automatic test_reject();
      fire(2'b10, 3'd0, 3'd0, 10);
      tests++;
      if (pulses !== 1 || result !== 2'd3 || shots !== 5'd1) begin
         fails++; $display("FAIL rej_repeat: got pulses=%0d result=%0d shots=%0d want 1 3 1", pulses, result, shots);
      end
      fire(2'b10, 3'd7, 3'd0, 10);
      tests++;
      if (pulses !== 1 || result !== 2'd3 || shots !== 5'd1) begin
         fails++; $display("FAIL rej_row: got pulses=%0d result=%0d shots=%0d want 1 3 1", pulses, result, shots);
      end
      fire(2'b10, 3'd0, 3'd5, 10);
      tests++;
      if (pulses !== 1 || result !== 2'd3 || shots !== 5'd1) begin
         fails++; $display("FAIL rej_col: got pulses=%0d result=%0d shots=%0d want 1 3 1", pulses, result, shots);
      end
      fire(2'b01, 3'd1, 3'd2, 10);
      tests++;
      if (pulses !== 1 || result !== 2'd3 || shots !== 5'd1 || hits !== 4'd1) begin
         fails++; $display("FAIL rej_mode: got pulses=%0d result=%0d shots=%0d hits=%0d want 1 3 1 1", pulses, result, shots, hits);
      end
      tests++;
      if (attack_map !== bit_of(34)) begin
         fails++; $display("FAIL rej_map: got %h want %h", attack_map, bit_of(34));
      end
   endtask

   task automatic test_miss();
      fire(2'b10, 3'd3, 3'd3, 10);
      tests++;
      if (pulses !== 1 || result !== 2'd1 || shots !== 5'd2 || hits !== 4'd1) begin
         fails++; $display("FAIL miss: got pulses=%0d result=%0d shots=%0d hits=%0d want 1 1 2 1", pulses, result, shots, hits);
      end
      tests++;
      if (attack_map !== (bit_of(34) | bit_of(16)) || hit_map !== bit_of(34)) begin
         fails++; $display("FAIL miss_maps: got %h %h", attack_map, hit_map);
      end
   endtask

   // Third accepted shot is also the winning one: victory wins over the budget.
   task automatic test_win();
      fire(2'b10, 3'd1, 3'd2, 10);
      tests++;
      if (pulses !== 1 || go_at_pulse !== 1'b1) begin
         fails++; $display("FAIL win_edge: got pulses=%0d game_over=%b want 1 1", pulses, go_at_pulse);
      end
      tests++;
      if (result !== 2'd2 || hits !== 4'd2 || shots !== 5'd3) begin
         fails++; $display("FAIL win_state: got result=%0d hits=%0d shots=%0d want 2 2 3", result, hits, shots);
      end
      ship_map = '0;
      fire(2'b10, 3'd6, 3'd4, 10);
      tests++;
      if (pulses !== 0 || game_over !== 1'b1 || busy !== 1'b1 || shots !== 5'd3) begin
         fails++; $display("FAIL over_ignore: got pulses=%0d go=%b busy=%b shots=%0d want 0 1 1 3", pulses, game_over, busy, shots);
      end
      tests++;
      if (hit_map !== (bit_of(34) | bit_of(27))) begin
         fails++; $display("FAIL over_hitmap: got %h want %h", hit_map, bit_of(34) | bit_of(27));
      end
   endtask

   task automatic test_shot_limit();
      do_reset();
      ship_map = bit_of(34) | bit_of(27);
      fire(2'b10, 3'd6, 3'd4, 10);
      fire(2'b10, 3'd2, 3'd0, 10);
      fire(2'b10, 3'd4, 3'd1, 10);
      tests++;
      if (result !== 2'd1 || shots !== 5'd3 || hits !== 4'd0) begin
         fails++; $display("FAIL limit_count: got result=%0d shots=%0d hits=%0d want 1 3 0", result, shots, hits);
      end
      tests++;
      if (game_over !== LIM || go_at_pulse !== LIM) begin
         fails++; $display("FAIL limit_over: got %b/%b want %b", game_over, go_at_pulse, LIM);
      end
      tests++;
      if (attack_map !== (bit_of(0) | bit_of(24) | bit_of(13)) || hit_map !== 35'd0) begin
         fails++; $display("FAIL limit_maps: got %h %h", attack_map, hit_map);
      end
      fire(2'b10, 3'd5, 3'd0, 10);
      tests++;
      if (pulses !== (LIM ? 0 : 1) || shots !== (LIM ? 5'd3 : 5'd4)) begin
         fails++; $display("FAIL limit_fourth: got pulses=%0d shots=%0d", pulses, shots);
      end
   endtask

   task automatic test_reset_mid_press();
      mode = 2'b10; row = 3'd0; col = 3'd1;
      btn_fire = 1'b1;
      repeat (4) @(negedge clk);
      tests++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL midpress_busy: got %b want 1", busy);
      end
      clr_n = 1'b0;
      #1;
      tests++;
      if ({attack_map, hit_map, hits, shots, result, shot_valid, game_over, busy} !== 84'd0) begin
         fails++; $display("FAIL midpress_reset: got shots=%0d attack=%h go=%b busy=%b", shots, attack_map, game_over, busy);
      end
      btn_fire = 1'b0;
      @(negedge clk);
      clr_n = 1'b1;
      repeat (10) @(negedge clk);
      tests++;
      if (shots !== 5'd0 || busy !== 1'b0 || shot_valid !== 1'b0) begin
         fails++; $display("FAIL midpress_after: got shots=%0d busy=%b sv=%b want 0 0 0", shots, busy, shot_valid);
      end
   endtask

   initial begin
      clr_n = 1'b0; btn_fire = 1'b0; mode = 2'b00; row = '0; col = '0; ship_map = '0;
      @(negedge clk);
      test_reset();
      test_first_hit();
      test_glitch();
      test_reject();
      test_miss();
      test_win();
      test_shot_limit();
      test_reset_mid_press();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
